rr_onehot_arbiter: RTL and testbench
====================================

# rr_onehot_arbiter

- Sequential round-robin arbiter that collects request events on four lines and issues one grant at a time as a one-hot vector.
- The grant vector is guaranteed to have at most one bit set, so the downstream 4:2 encoder can turn it into a 2-bit index.
- A valid/ready handshake on the grant side lets the consumer stall.
- Request events that arrive while the arbiter is busy are held in sticky pending flags and served in round-robin order.

## Interface
Parameters:
- N_REQ, 4: number of request lines; fixed at 4 to match the 4:2 encoder; other values are unsupported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request events; bit i high on a rising edge is one event for requester i.
- grant  output  4  one-hot grant to the encoder; 4'b0000 when grant_valid=0.
- grant_valid  output  1  grant holds a live grant.
- grant_ready  input  1  consumer accepts; handshake = grant_valid & grant_ready at the rising edge.
- pending  output  4  registered sticky flags of requests not yet granted.
- drop  output  1  one-cycle pulse: an event arrived on a line already pending and was coalesced.

## Operation
- Reset (async, active-high): grant=0, grant_valid=0, pending=0, drop=0, ptr=0, state=IDLE.
- Any grant or queued request in flight at reset is discarded.
- Effective request vector: eff = pending | req.
- State IDLE:
  - If eff != 0, pick the winner by a rotating search: index ptr first, then ptr+1, ptr+2, ptr+3 (mod 4).
  - Register the winner as grant, set grant_valid=1, and go to GRANT.
  - The winner's pending bit ends cleared; all other eff bits end set in pending.
- State GRANT, no handshake: grant and grant_valid hold unchanged. pending |= req.
- State GRANT, handshake:
  - ptr <= granted index + 1 (mod 4).
  - Compute eff from pending | req, excluding the granted bit unless req carries that bit this cycle.
  - If eff != 0, pick the next winner from the new ptr, load it back-to-back, and stay in GRANT.
  - If eff == 0, clear grant and grant_valid and go to IDLE.
- Coalescing:
  - req[i]=1 while pending[i]=1 already: drop=1 for the next cycle; pending[i] stays 1.
  - Multiple lines coalescing in the same cycle produce a single drop pulse.
- The requester currently granted may re-request during its grant.
  - The new event sets pending[i] and is not lost, including when it coincides with the handshake.
- Invariant: grant is one-hot or zero, and grant != 0 exactly when grant_valid=1.

## Timing
- Latency from req[i] sampled at edge k, in IDLE and uncontended: grant/grant_valid high after edge k (visible in cycle k+1).
- Throughput: one grant per cycle when grant_ready is held high and requests stay queued.
- grant, grant_valid, pending and drop are all registered; there are no combinational paths from inputs to outputs.
- grant_ready is ignored while grant_valid=0.
- Fairness: with all four lines continuously pending and ready high, grants cycle 0,1,2,3,0,... from reset.

## Structure
- Shared package arb_pkg holds:
  - N_REQ=4 and PTR_W=2.
  - State encodings IDLE=1'b0, GRANT=1'b1.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: eff[3:0], ptr[1:0].
  - Outputs: onehot[3:0], idx[1:0], any.
  - Instantiated once.
- The top level holds the state register, ptr, pending, the grant registers and drop.

## Test plan
- Reset mid-grant: grant=4'b0100, valid=1, assert rst asynchronously -> all outputs 0 immediately; pending=0; first later request on line 0 is granted first (ptr=0).
- Single request: req=4'b0010 for one cycle, ready=1 -> grant=4'b0010, valid=1 the next cycle, encoder output 2'b01; valid drops one cycle later.
- Contention: req=4'b1111 for one cycle, ready=1 -> grants 0001, 0010, 0100, 1000 on four consecutive cycles; drop never asserted; then idle.
- Stall: grant=4'b0001 with ready=0 for 5 cycles while req=4'b1000 pulses -> grant stable, pending=4'b1000; on ready=1 the next grant is 4'b1000.
- Coalesce: pending[2]=1 and req=4'b0100 again -> drop pulses one cycle; only one grant 4'b0100 is issued.
- Re-request on handshake: grant=4'b0001 accepted in the same cycle that req=4'b0001 -> grant 4'b0001 issued again after the other pending lines, per ptr=1 order.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the round-robin one-hot arbiter.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam int PTR_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;
endpackage

// File: rtl/rr_onehot_arbiter_pick.sv
// Rotate-priority picker: first set bit of eff searching from ptr upward, mod N_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is consumed.
module rr_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] eff,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PTR_W-1:0] idx,
    output logic             any
);
    logic [PTR_W-1:0] cand;

    // Walk the rotation backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        onehot = '0;
        idx    = '0;
        cand   = '0;
        any    = |eff;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = ptr + PTR_W'(k);
            if (eff[cand]) begin
                onehot = N_REQ'(1) << cand;
                idx    = cand;
            end
        end
    end
endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter: sticky per-line pending flags, one registered one-hot grant at a time.
// Latency: request sampled at edge k is granted after edge k when idle and uncontended.
// Backpressure: grant holds while grant_ready is low; new events accumulate in pending.
module rr_onehot_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [N_REQ-1:0] pending,
    output logic             drop
);
    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, ptr_nxt;
    logic [PTR_W-1:0] gidx, gidx_nxt;
    logic [N_REQ-1:0] grant_nxt, pending_nxt;
    logic             grant_valid_nxt, drop_nxt;

    logic             hs;
    logic [N_REQ-1:0] eff;
    logic [PTR_W-1:0] pick_ptr;
    logic [N_REQ-1:0] pick_onehot;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_any;

    assign hs       = (state == GRANT) && grant_valid && grant_ready;
    // The granted line's own pending bit is cleared at grant time, so any bit set there
    // now is a fresh re-request and must stay eligible.
    assign eff      = pending | req;
    assign pick_ptr = hs ? (gidx + PTR_W'(1)) : ptr;

    rr_pick u_pick (
        .eff    (eff),
        .ptr    (pick_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_nxt       = state;
        ptr_nxt         = ptr;
        gidx_nxt        = gidx;
        grant_nxt       = grant;
        grant_valid_nxt = grant_valid;
        pending_nxt     = pending;
        drop_nxt        = |(req & pending);
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nxt       = GRANT;
                    grant_nxt       = pick_onehot;
                    gidx_nxt        = pick_idx;
                    grant_valid_nxt = 1'b1;
                    pending_nxt     = eff & ~pick_onehot;
                end
            end
            GRANT: begin
                if (!hs) begin
                    pending_nxt = pending | req;
                end else begin
                    ptr_nxt = gidx + PTR_W'(1);
                    if (pick_any) begin
                        grant_nxt   = pick_onehot;
                        gidx_nxt    = pick_idx;
                        pending_nxt = eff & ~pick_onehot;
                    end else begin
                        state_nxt       = IDLE;
                        grant_nxt       = '0;
                        grant_valid_nxt = 1'b0;
                        pending_nxt     = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            gidx        <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            pending     <= '0;
            drop        <= 1'b0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            gidx        <= gidx_nxt;
            grant       <= grant_nxt;
            grant_valid <= grant_valid_nxt;
            pending     <= pending_nxt;
            drop        <= drop_nxt;
        end
    end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed scenarios plus random traffic checked against a queue-of-flags reference model.
module tb_rr_onehot_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic       grant_ready;
    logic [3:0] pending;
    logic       drop;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    bit       m_busy;
    int       m_gidx;
    int       m_ptr;
    bit [3:0] m_pend;
    bit       m_drop;

    always #5 clk = ~clk;

    rr_onehot_arbiter #(.N_REQ(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_ready (grant_ready),
        .pending     (pending),
        .drop        (drop)
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input bit [3:0] e, input int p);
        for (int k = 0; k < 4; k++)
            if (e[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_gidx = 0; m_ptr = 0; m_pend = '0; m_drop = 0;
    endtask

    task automatic model_step(input bit [3:0] r, input bit rdy);
        bit [3:0] e;
        int       w;
        m_drop = |(r & m_pend);
        if (!m_busy) begin
            e = m_pend | r;
            w = pick(e, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_gidx = w;
                m_pend = e & ~(4'b0001 << w);
            end
        end else if (!rdy) begin
            m_pend = m_pend | r;
        end else begin
            m_ptr = (m_gidx + 1) % 4;
            e = m_pend | r;
            w = pick(e, m_ptr);
            if (w >= 0) begin
                m_gidx = w;
                m_pend = e & ~(4'b0001 << w);
            end else begin
                m_busy = 0;
                m_pend = '0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] eg;
        eg = m_busy ? (4'b0001 << m_gidx) : 4'b0000;
        check({tag, ".grant"},   grant,              eg);
        check({tag, ".valid"},   {3'b000, grant_valid}, {3'b000, m_busy});
        check({tag, ".pending"}, pending,            m_pend);
        check({tag, ".drop"},    {3'b000, drop},     {3'b000, m_drop});
        if (grant_valid && grant != 4'b0000) begin
            check({tag, ".enc"}, {2'b00, enc(grant)}, {2'b00, 2'(m_gidx)});
        end
    endtask

    function automatic logic [1:0] enc(input logic [3:0] g);
        for (int i = 0; i < 4; i++)
            if (g[i]) return 2'(i);
        return 2'b00;
    endfunction

    task automatic cycle(input string tag, input logic [3:0] r, input logic rdy);
        @(negedge clk);
        check_outputs(tag);
        req = r;
        grant_ready = rdy;
        @(posedge clk);
        model_step(r, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req = '0; grant_ready = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1 check_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = '0; grant_ready = 1'b0;
        model_reset();
        #3 check_outputs("por");
        #9 rst = 1'b0;

        // single request, then idle
        cycle("single", 4'b0010, 1'b1);
        cycle("single", 4'b0000, 1'b1);
        cycle("single", 4'b0000, 1'b1);
        cycle("single", 4'b0000, 1'b1);

        // contention from reset: 0,1,2,3 order, then idle
        do_reset();
        cycle("cont", 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) cycle("cont", 4'b0000, 1'b1);

        // stall with pulsing request on line 3
        do_reset();
        cycle("stall", 4'b0001, 1'b0);
        for (int i = 0; i < 5; i++) cycle("stall", (i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cycle("stall", 4'b0000, 1'b1);

        // coalesce on line 2 while line 0 is stalled
        do_reset();
        cycle("coal", 4'b0001, 1'b0);
        cycle("coal", 4'b0100, 1'b0);
        cycle("coal", 4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) cycle("coal", 4'b0000, 1'b1);

        // re-request by the granted line on its handshake
        do_reset();
        cycle("rereq", 4'b0111, 1'b0);
        cycle("rereq", 4'b0001, 1'b1);
        for (int i = 0; i < 5; i++) cycle("rereq", 4'b0000, 1'b1);

        // asynchronous reset in the middle of a live grant
        do_reset();
        cycle("midrst", 4'b0100, 1'b0);
        cycle("midrst", 4'b0000, 1'b0);
        do_reset();
        cycle("midrst", 4'b0001, 1'b1);
        cycle("midrst", 4'b0000, 1'b1);
        cycle("midrst", 4'b0000, 1'b1);

        // random traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            logic       rdy;
            r   = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            rdy = ($urandom_range(0, 3) != 0);
            cycle("rand", r, rdy);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        cycle("final", 4'b0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
